// File: rtl/sm2_mod_mul.sv
// Purpose: 256-bit modular multiplier (a*b) mod n, bit-serial MSB-first interleaved shift/add/reduce.
// Latency: W+1 cycles from accepted start to the done pulse; range error gives done 1 cycle after start.
// Backpressure: start is ignored while busy; result/err hold until the next accepted start (no output stall).
module sm2_mod_mul #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  n_reg;
    logic [W+1:0]  acc;
    logic [CW-1:0] cnt;

    logic          range_bad;
    logic [W+1:0]  n_ext;
    logic [W+1:0]  a_ext;
    logic [W+1:0]  t_dbl;
    logic [W+1:0]  t_red;
    logic [W+1:0]  t_add;
    logic [W+1:0]  t_nxt;

    // Operand check on the raw inputs; only consulted in IDLE when start is sampled.
    assign range_bad = (a >= n) || (b >= n) || (n == '0);

    // One Horner step: acc = (2*acc + b_i*a) mod n, with two conditional subtractions.
    // acc < n < 2^W, so 2*acc and 2*acc - n + a both fit in W+2 bits.
    always_comb begin
        n_ext = {2'b00, n_reg};
        a_ext = {2'b00, a_reg};
        t_dbl = acc << 1;
        t_red = (t_dbl >= n_ext) ? (t_dbl - n_ext) : t_dbl;
        t_add = b_reg[cnt] ? (t_red + a_ext) : t_red;
        t_nxt = (t_add >= n_ext) ? (t_add - n_ext) : t_add;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: bad operands skip straight to DONE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = range_bad ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            CALC: begin
                busy = 1'b1;
                done = 1'b0;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: latch operands on accepted start, iterate in CALC, publish result entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            n_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        n_reg <= n;
                        if (range_bad) begin
                            err    <= 1'b1;
                            result <= '0;
                        end else begin
                            acc <= '0;
                            cnt <= CW'(W - 1);
                            err <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    acc <= t_nxt;
                    if (cnt == '0) begin
                        result <= t_nxt[W-1:0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm2_mod_mul.sv
module tb_sm2_mod_mul;

    localparam int W = 256;
    localparam logic [W-1:0] SM2_N = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF7203DF6B21C6052B53BBF40939D54123;
    localparam logic [W-1:0] B_ID  = 256'h6CB28D99385C175C94F94E934817663FC176D925DD72B727260DBAAE1FB2F96F;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] n     = '0;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    sm2_mod_mul #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           t_start;
        int           t_done;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
        end
    endtask

    // Reference: full double-width product reduced with the % operator.
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] m);
        logic [2*W-1:0] p;
        logic [2*W-1:0] r;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        r = p % {{W{1'b0}}, m};
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom())};
        return r;
    endfunction

    // Called at posedge+#1 of a cycle in which the DUT is idle.
    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] in);
        exp_t e;
        logic bad;
        a = ia;
        b = ib;
        n = in;
        start = 1'b1;
        bad = (ia >= in) || (ib >= in) || (in == '0);
        e.res = bad ? '0 : model(ia, ib, in);
        e.err = bad;
        e.t_start = cyc;
        e.t_done = cyc + (bad ? 1 : W + 1);
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < W + 20 && q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d ops outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: busy and done are checked every cycle against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", W'(busy), W'(q.size() > 0 && cyc > q[0].t_start && cyc <= q[0].t_done));
            if (q.size() > 0 && cyc == q[0].t_done) begin
                chk("done_pulse", W'(done), W'(1'b1));
                chk("result", result, q[0].res);
                chk("err", W'(err), W'(q[0].err));
                void'(q.pop_front());
            end else begin
                chk("done_quiet", W'(done), W'(1'b0));
            end
        end
    end

    initial begin
        logic [W-1:0] half;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] rn;
        int t0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_err", W'(err), '0);
        chk("rst_result", result, '0);
        @(posedge clk);
        #1;

        // Small values
        start_op(3, 5, 7);
        wait_idle();
        chk("small_const", result, 1);

        // SM2 order corner cases
        start_op(SM2_N - 1, SM2_N - 1, SM2_N);
        wait_idle();
        chk("nm1_sq", result, 1);
        half = (SM2_N >> 1) + 1;
        start_op(2, half, SM2_N);
        wait_idle();
        chk("two_half", result, 1);

        // Zero and identity
        start_op(0, rand_w() % SM2_N, SM2_N);
        wait_idle();
        chk("zero", result, 0);
        start_op(1, B_ID, SM2_N);
        wait_idle();
        chk("identity", result, B_ID);

        // Range errors and recovery
        start_op(7, 1, 7);
        wait_idle();
        chk("rng_err_flag", W'(err), 1);
        start_op(3, 5, 7);
        wait_idle();
        chk("rng_clear_err", W'(err), 0);
        start_op(1, 9, 7);
        wait_idle();
        start_op(0, 0, 0);
        wait_idle();
        start_op(0, 0, 1);
        wait_idle();
        chk("n_one", W'(err), 0);

        // Ignored starts and late input changes
        ra = rand_w() % SM2_N;
        rb = rand_w() % SM2_N;
        t0 = cyc;
        start_op(ra, rb, SM2_N);
        wait_cyc(t0 + 5);
        a = rand_w();
        b = rand_w();
        n = rand_w();
        wait_cyc(t0 + 100);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cyc(t0 + W + 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("ignored_result", result, model(ra, rb, SM2_N));

        // Reset mid-operation
        start_op(3, 5, 7);
        wait_idle();
        t0 = cyc;
        start_op(rand_w() % SM2_N, rand_w() % SM2_N, SM2_N);
        wait_cyc(t0 + 50);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_result", result, '0);
        chk("abort_err", W'(err), '0);
        @(posedge clk);
        #1;
        start_op(5, 6, 7);
        wait_idle();

        // Randomized operands and moduli
        for (int it = 0; it < 8; it++) begin
            rn = (it % 2 == 0) ? SM2_N : (rand_w() >> $urandom_range(0, 200));
            if (rn == '0) rn = 1;
            ra = rand_w() % rn;
            rb = (it == 5) ? rn : (rand_w() % rn);
            start_op(ra, rb, rn);
            wait_idle();
        end

        repeat (5) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm2_mod_mul.md
Name: sm2_mod_mul

Overview:
- Sequential 256-bit modular multiplier, bit-serial interleaved shift/add/reduce; computes result = (a*b) mod n.
- Sits directly downstream of sm2_signature's CAL_r stage: consumes r, dA, k and (1+dA)^-1 to build s = ((1+dA)^-1 * (k - r*dA)) mod n.
- Replaces the illegal combinational `*`/`%` operators in the signature datapath.
- Also reused for mod-p field products in the kG point-multiplication core.

Parameters:
- W, 256, operand/modulus width in bits; all arithmetic is sized from W.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  W  multiplicand, must satisfy a < n
- b  input  W  multiplier, must satisfy b < n
- n  input  W  modulus (SM2 order n or prime p), must be nonzero
- busy  output  1  high while an operation is in flight (CALC or DONE)
- done  output  1  single-cycle completion pulse
- err  output  1  operand check failed for the last accepted operation
- result  output  W  (a*b) mod n; valid from the done cycle until the next accepted start

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, done=0, err=0, result=0, internal accumulator/counter=0. Reset overrides every other input, including mid-CALC; the aborted operation produces no done pulse.
- States: IDLE -> CALC -> DONE -> IDLE. An error path goes IDLE -> DONE directly.
- IDLE, start=1 at cycle T:
  - latch a, b, n into internal registers; later input changes have no effect.
  - If a>=n, b>=n or n==0: next state=DONE, err<=1, result<=0.
  - Otherwise: acc<=0, cnt<=W-1, err<=0, next state=CALC.
- CALC: one multiplier bit per cycle, MSB first. Per cycle i=cnt, acc is W+2 bits internally:
  - t = 2*acc; if t>=n then t=t-n
  - if b_reg[i] then t=t+a_reg; if t>=n then t=t-n
  - acc<=t
  - If cnt==0: result<=t[W-1:0] and next state=DONE. Otherwise cnt<=cnt-1.
- Invariant: acc < n after every CALC cycle; the final result is always < n.
- DONE: done=1 for exactly this cycle, busy=1, next state=IDLE.
- Latency, normal path: start at cycle T gives CALC in cycles T+1..T+W and done=1 in cycle T+W+1 (257 cycles for W=256).
- Latency, error path: done=1 in cycle T+1.
- busy=1 in CALC and DONE; busy=0 in IDLE, including the start cycle T. Start is ignored whenever state != IDLE, including the DONE cycle, so back-to-back accepted starts are at least W+2 cycles apart.
- result and err hold their values in IDLE until the next accepted start. err and result update at the same edge that enters DONE; result is not modified during CALC.
- n==1 with a=b=0 passes the range check and returns 0.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Small values: W=256, n=7, a=3, b=5, start pulse at cycle T -> done=1 exactly at T+257, result=1, err=0, busy high T+1..T+257.
- SM2 order: n=FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF7203DF6B21C6052B53BBF40939D54123, a=b=n-1 -> result=1. Then a=2, b=(n+1)/2 -> result=1.
- Zero/identity: a=0 with any b<n -> result=0. a=1, b=6CB28D99385C175C94F94E934817663FC176D925DD72B727260DBAAE1FB2F96F with SM2 n -> result equals b.
- Range error: n=7, a=7, b=1 -> done at T+1, err=1, result=0. A following valid op (3*5 mod 7) clears err and gives result=1.
- Ignored start: second start asserted at T+100 and again during the DONE cycle -> no restart, single done at T+257 with the first operation's result. Inputs changed at T+5 do not affect the result.
- Reset mid-operation: rst=1 at T+50 -> next cycle busy=0, done=0, result=0, err=0, no done pulse. A fresh start afterwards completes normally after 257 cycles.
